// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the M stage.
// It accepts one load/store at a time and adds WAIT_CYCLES wait states.
// It then performs a byte-enabled access on a word RAM and returns a one-cycle response.
// Optional write log: define DM_WRITE_LOG_EN to print every committed store.
module dm_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned DEPTH    = 1 << (ADDR_W - 2);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] ram [DEPTH];

  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:2] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] lat_pc;

  logic        src_we;
  logic [3:0]  src_be;
  logic [31:2] src_addr;
  logic [31:0] src_wdata;
  logic [31:0] src_pc;

  logic              commit;
  logic              commit_err;
  logic [ADDR_W-3:0] idx;
  logic [31:0]       old_word;
  logic [31:0]       merged;
  logic [31:0]       commit_rdata;

  assign busy = ~req_ready;

  // Select the request that commits on this edge.
  // With zero wait states, the commit edge is the accept edge.
  // The live inputs are then used because the latches are not loaded yet.
  always_comb begin
    src_we    = lat_we;
    src_be    = lat_be;
    src_addr  = lat_addr;
    src_wdata = lat_wdata;
    src_pc    = lat_pc;
    if (state == IDLE) begin
      src_we    = req_we;
      src_be    = req_be;
      src_addr  = req_addr[31:2];
      src_wdata = req_wdata;
      src_pc    = req_pc;
    end
  end

  // Commit decode: error check, RAM lookup and byte-lane merge.
  always_comb begin
    commit       = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                   ((state == WAIT) && (cnt == 4'd0));
    commit_err   = (src_addr[31:ADDR_W] != '0) || (src_be == 4'b0000);
    idx          = src_addr[ADDR_W-1:2];
    old_word     = ram[idx];
    merged       = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (src_be[i]) merged[8*i +: 8] = src_wdata[8*i +: 8];
    end
    commit_rdata = commit_err ? '0 : old_word;
  end

  // Word RAM: reset clears every word; non-error stores write the merged word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (commit && src_we && !commit_err) begin
      ram[idx] <= merged;
`ifdef DM_WRITE_LOG_EN
      $display("%d@%h: *%h <= %h", $time, src_pc, {src_addr, 2'b00}, merged);
`endif
    end
  end

`ifndef DM_WRITE_LOG_EN
  logic unused_pc;
  assign unused_pc = ^src_pc;
`endif
  logic unused_lane;
  assign unused_lane = ^req_addr[1:0];

  // Handshake FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_pc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          if (req_valid) begin
            lat_we    <= req_we;
            lat_be    <= req_be;
            lat_addr  <= req_addr[31:2];
            lat_wdata <= req_wdata;
            lat_pc    <= req_pc;
            req_ready <= 1'b0;
            cnt       <= CNT_INIT;
            if (WAIT_CYCLES == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= commit_rdata;
              resp_err   <= commit_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= commit_rdata;
            resp_err   <= commit_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder.
// One instance uses WAIT_CYCLES=2 and a second instance uses WAIT_CYCLES=0.
// A word-array reference model predicts every response.
module tb_dm_responder;

  localparam int unsigned WC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        z_valid, z_we;
  logic [3:0]  z_be;
  logic [31:0] z_addr, z_wdata, z_pc;
  logic        z_ready, z_resp_valid, z_err, z_busy;
  logic [31:0] z_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [1024];

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(12), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_pc(req_pc), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  dm_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) u_zero (
    .clk(clk), .reset(reset), .req_valid(z_valid), .req_ready(z_ready),
    .req_we(z_we), .req_be(z_be), .req_addr(z_addr), .req_wdata(z_wdata),
    .req_pc(z_pc), .resp_valid(z_resp_valid), .resp_rdata(z_rdata),
    .resp_err(z_err), .busy(z_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Send one request to the WAIT_CYCLES=2 instance and check its response.
  // The expected result is derived from the model.
  // Call this task at a falling edge.
  task automatic do_req(input string tag, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic        e_err;
    logic [31:0] e_rdata, word;
    int          n;
    e_err   = (addr[31:12] != 0) || (be == 4'b0000);
    word    = model[addr[11:2]];
    e_rdata = e_err ? 32'h0 : word;
    if (we && !e_err) begin
      for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
      model[addr[11:2]] = word;
    end
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr;
    req_wdata = wdata; req_pc = $urandom;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_accept_timeout"}, 32'(n < 50), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (resp_valid !== 1'b1 && n <= int'(WC) + 5) begin
      chk({tag, "_ready_low"}, 32'(req_ready), 32'd0);
      chk({tag, "_busy_high"}, 32'(busy), 32'd1);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(WC + 1));
    chk({tag, "_ready_in_resp"}, 32'(req_ready), 32'd0);
    chk({tag, "_rdata"}, resp_rdata, e_rdata);
    chk({tag, "_err"}, 32'(resp_err), 32'(e_err));
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
    chk({tag, "_rdata_clr"}, resp_rdata, 32'd0);
    chk({tag, "_err_clr"}, 32'(resp_err), 32'd0);
    chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] prev, a, d;
    logic [3:0]  b;
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_be = '0; req_addr = '0;
    req_wdata = '0; req_pc = '0;
    z_valid = 1'b0; z_we = 1'b0; z_be = '0; z_addr = '0; z_wdata = '0; z_pc = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);

    do_req("load10", 1'b0, 4'hF, 32'h10, 32'h0);
    do_req("st20", 1'b1, 4'hF, 32'h20, 32'hDEADBEEF);
    do_req("ld20", 1'b0, 4'hF, 32'h20, 32'h0);
    do_req("st20_b0", 1'b1, 4'b0001, 32'h20, 32'h000000AB);
    do_req("ld20_b0", 1'b0, 4'hF, 32'h20, 32'h0);
    do_req("st20_hi", 1'b1, 4'b1100, 32'h20, 32'h12340000);
    do_req("ld20_hi", 1'b0, 4'hF, 32'h20, 32'h0);
    do_req("ld_oor", 1'b0, 4'hF, 32'h1000, 32'h0);
    do_req("st_be0", 1'b1, 4'b0000, 32'h0, 32'hFFFFFFFF);
    do_req("st_oor", 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D);
    do_req("ld0", 1'b0, 4'hF, 32'h0, 32'h0);

    // Reset during WAIT: the store must be discarded and the RAM cleared.
    do_req("st4_pre", 1'b1, 4'hF, 32'h4, 32'h55555555);
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 32'h4;
    req_wdata = 32'h11111111;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_ready_low", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    do_req("ld4_after_rst", 1'b0, 4'hF, 32'h4, 32'h0);
    do_req("ld20_after_rst", 1'b0, 4'hF, 32'h20, 32'h0);

    for (int t = 0; t < 60; t++) begin
      a = {20'h0, 6'($urandom_range(0, 63)), 4'h0, 2'($urandom)};
      if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom_range(1, 1 << 20 - 1));
      b = 4'($urandom_range(0, 15));
      d = $urandom;
      do_req("rand", 1'($urandom), b, a, d);
    end

    // WAIT_CYCLES=0 with req_valid held high: one accept every second cycle.
    // Each store returns the word written by the previous store.
    prev = 32'h0;
    z_valid = 1'b1; z_we = 1'b1; z_be = 4'hF; z_addr = 32'h8; z_wdata = $urandom;
    for (int k = 0; k < 6; k++) begin
      chk("z_ready_idle", 32'(z_ready), 32'd1);
      chk("z_no_resp_idle", 32'(z_resp_valid), 32'd0);
      @(negedge clk);
      chk("z_resp_valid", 32'(z_resp_valid), 32'd1);
      chk("z_ready_resp", 32'(z_ready), 32'd0);
      chk("z_rdata_prev", z_rdata, prev);
      chk("z_err", 32'(z_err), 32'd0);
      prev = z_wdata;
      @(negedge clk);
      z_wdata = $urandom;
    end
    z_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
